// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified line-wide main memory between the I-cache and
// D-cache miss paths; one fixed-latency access at a time, done pulse on completion.
module mem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int LINE_W     = 64,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              i_done,
  output logic              d_done,
  output logic [LINE_W-1:0] rdata,
  output logic              busy,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int LAT_W    = 4;
  localparam int STARVE_W = 3;

  localparam logic [LAT_W-1:0]    LAT_LOAD = LAT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q,      state_d;
  logic [LAT_W-1:0]     lat_cnt_q,    lat_cnt_d;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic                 mask_i_q,     mask_i_d;
  logic                 mask_d_q,     mask_d_d;
  logic                 served_i_q,   served_i_d;
  logic                 we_q,         we_d;
  logic [ADDR_W-1:0]    addr_q,       addr_d;
  logic [LINE_W-1:0]    wdata_q,      wdata_d;
  logic [LINE_W-1:0]    rdata_q,      rdata_d;

  logic elig_i;
  logic elig_d;
  logic grant_i;
  logic grant_d;

  // A requester just served is masked for one IDLE cycle so its still-high
  // req (it only drops after seeing done) is not mistaken for a new request.
  assign elig_i  = i_req & ~mask_i_q;
  assign elig_d  = d_req & ~mask_d_q;
  assign grant_i = elig_i & (~elig_d | (starve_cnt_q == STARVE_LIM));
  assign grant_d = elig_d & ~grant_i;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mask_i_d     = 1'b0;
    mask_d_d     = 1'b0;
    served_i_d   = served_i_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = I_ACC;
          lat_cnt_d    = LAT_LOAD;
          served_i_d   = 1'b1;
          we_d         = 1'b0;
          addr_d       = i_addr;
          starve_cnt_d = '0;
        end else if (grant_d) begin
          state_d    = D_ACC;
          lat_cnt_d  = LAT_LOAD;
          served_i_d = 1'b0;
          we_d       = d_we;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          // Counts D grants that bypassed a waiting I-cache, saturating.
          if (!i_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
          end
        end
      end

      I_ACC, D_ACC: begin
        if (lat_cnt_q == '0) begin
          state_d = DONE;
          if ((state_q == I_ACC) || !we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end

      DONE: begin
        state_d  = IDLE;
        mask_i_d = served_i_q;
        mask_d_d = ~served_i_q;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      mask_i_q     <= 1'b0;
      mask_d_q     <= 1'b0;
      served_i_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mask_i_q     <= mask_i_d;
      mask_d_q     <= mask_d_d;
      served_i_q   <= served_i_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode straight from registered state, so a reset mid-access
  // drops the enables on the very next edge without a done pulse.
  assign busy      = (state_q != IDLE);
  assign mem_re    = (state_q == I_ACC) | ((state_q == D_ACC) & ~we_q);
  assign mem_we    = (state_q == D_ACC) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign i_done    = (state_q == DONE) & served_i_q;
  assign d_done    = (state_q == DONE) & ~served_i_q;

endmodule
